// File: rtl/decode_imm_stage.sv
// ---------------------------------------------------------------------------
// decode_imm_stage
//
// Purpose:
//   Pipeline stage between the opcode decoder and the register-read stage.
//   It expands the immediate field of the incoming instruction according to
//   the format chosen by the opcode decoder. The instruction, its address and
//   the expanded immediate pass through a two-entry skid buffer, so in_ready
//   is a pure register output with no combinational path from out_ready.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - synchronous active-high reset
//   in_valid     - upstream slot holds an instruction
//   in_ready     - stage can accept an instruction this cycle (registered)
//   in_instr     - raw 32-bit instruction word
//   in_pc        - 32-bit instruction address
//   in_imm_type  - immediate format (IMM_NONE/I/S/B/U/J/C, 3-bit encoding)
//   flush        - discard every held and incoming instruction
//   out_valid    - output slot holds a result
//   out_ready    - downstream accepts this cycle
//   out_instr    - forwarded instruction word
//   out_pc       - forwarded instruction address
//   out_imm      - expanded 32-bit immediate
// ---------------------------------------------------------------------------
module decode_imm_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_imm_type,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm
);

    // Immediate format encoding shared with the opcode decoder.
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_C    = 3'd6;

    // Main slot drives the outputs; the skid slot catches the one
    // instruction that can arrive while the main slot is stalled.
    logic        main_valid_q, main_valid_d;
    logic [31:0] main_instr_q, main_instr_d;
    logic [31:0] main_pc_q,    main_pc_d;
    logic [31:0] main_imm_q,   main_imm_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [31:0] skid_imm_q,   skid_imm_d;

    logic [31:0] imm_exp;
    logic        accept;
    logic        out_fire;

    // Immediate expansion on the input side so it is registered together
    // with the instruction it belongs to.
    always_comb begin
        imm_exp = 32'h0;
        case (in_imm_type)
            IMM_I:   imm_exp = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S:   imm_exp = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B:   imm_exp = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_U:   imm_exp = {in_instr[31:12], 12'b0};
            IMM_J:   imm_exp = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            IMM_C:   imm_exp = {27'b0, in_instr[19:15]};
            IMM_NONE: imm_exp = 32'h0;
            default: imm_exp = 32'h0;
        endcase
    end

    // in_ready is simply the inverse of the registered skid valid bit, so it
    // never sees out_ready combinationally. Flush suppresses any accept.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign out_fire = main_valid_q && out_ready;

    // Next-state of the skid buffer. When the main slot is empty or draining
    // it refills from the skid slot first (preserving order), otherwise from
    // the input. A stalled main slot pushes a new accept into the skid slot.
    // Flush only clears the valid bits; stale data is harmless.
    always_comb begin
        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        main_imm_d   = main_imm_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_instr_d = skid_instr_q;
                main_pc_d    = skid_pc_q;
                main_imm_d   = skid_imm_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                    main_imm_d   = imm_exp;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
            skid_imm_d   = imm_exp;
        end
    end

    // State registers; reset clears valid bits and data so the outputs read
    // zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_instr_q <= 32'h0;
            main_pc_q    <= 32'h0;
            main_imm_q   <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_imm_q   <= 32'h0;
        end else begin
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            main_imm_q   <= main_imm_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;
    assign out_imm   = main_imm_q;

endmodule

// File: tb/tb_decode_imm_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_imm_stage
//
// Purpose:
//   Self-checking bench for decode_imm_stage. Inputs change just after the
//   rising edge; a monitor on the falling edge records every input transfer
//   into a scoreboard queue and compares every output transfer against the
//   oldest queued entry.
// ---------------------------------------------------------------------------
module tb_decode_imm_stage;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_C    = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [2:0]  in_imm_type;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        int          acceptCycle;
    } sbEntry_t;

    sbEntry_t    sbQueue[$];
    logic [31:0] curExpImm;
    logic        checkLatency;
    int          cycleCount;
    int          checkCount;
    int          errorCount;

    decode_imm_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_imm_type (in_imm_type),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_imm     (out_imm)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure accept-to-output latency.
    initial cycleCount = 0;
    always @(posedge clk) cycleCount++;

    // Single point for every comparison: counts it, reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
        end
    endtask

    // Reference immediate expansion for the random traffic.
    function automatic logic [31:0] refImm(input logic [31:0] ins, input logic [2:0] typ);
        logic [31:0] r;
        r = 32'h0;
        case (typ)
            IMM_I: r = {{20{ins[31]}}, ins[31:20]};
            IMM_S: r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U: r = {ins[31:12], 12'b0};
            IMM_J: r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_C: r = {27'b0, ins[19:15]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Scoreboard monitor: reset and flush empty the queue, an output
    // transfer pops and compares, an input transfer pushes.
    always @(negedge clk) begin
        sbEntry_t e;
        if (rst || flush) begin
            sbQueue.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_output", out_pc, 32'hxxxx_xxxx ^ 32'h0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("out_instr", out_instr, e.instr);
                    checkOutput("out_pc", out_pc, e.pc);
                    checkOutput("out_imm", out_imm, e.imm);
                    if (checkLatency)
                        checkOutput("latency", 32'(cycleCount - e.acceptCycle), 32'd1);
                end
            end
            if (in_valid && in_ready) begin
                e.instr       = in_instr;
                e.pc          = in_pc;
                e.imm         = curExpImm;
                e.acceptCycle = cycleCount;
                sbQueue.push_back(e);
            end
        end
    end

    task automatic syncInputs();
        @(posedge clk);
        #1;
    endtask

    task automatic driveInput(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [2:0] typ, input logic [31:0] expImm);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_imm_type = typ;
        curExpImm   = expImm;
    endtask

    // Presents one instruction and holds it until accepted (bounded wait);
    // called and returns just after a rising edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [2:0] typ, input logic [31:0] expImm);
        int waitCycles;
        waitCycles = 0;
        driveInput(instr, pc, typ, expImm);
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) until every queued entry has been popped.
    task automatic drainQueue();
        int n;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            #1;
            if (sbQueue.size() == 0) break;
        end
        checkOutput("drain_empty", 32'(sbQueue.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=%0t required=done", $time);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount + 1);
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [31:0] rInstr;
        logic [2:0]  rType;
        checkCount   = 0;
        errorCount   = 0;
        checkLatency = 1'b0;
        rst          = 1'b1;
        flush        = 1'b0;
        out_ready    = 1'b0;
        in_valid     = 1'b0;
        in_instr     = 32'h0;
        in_pc        = 32'h0;
        in_imm_type  = IMM_NONE;
        curExpImm    = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_imm", out_imm, 32'h0);

        // Expansion vectors, back to back with out_ready high
        $display("[TB] expansion vectors");
        out_ready    = 1'b1;
        checkLatency = 1'b1;
        syncInputs();
        applyStimulus(32'hFFF00093, 32'h0000_0000, IMM_I, 32'hFFFFFFFF);
        applyStimulus(32'hFE20AE23, 32'h0000_0004, IMM_S, 32'hFFFFFFFC);
        applyStimulus(32'hFE000EE3, 32'h0000_0008, IMM_B, 32'hFFFFFFFC);
        applyStimulus(32'h12345037, 32'h0000_000C, IMM_U, 32'h12345000);
        applyStimulus(32'hFFDFF06F, 32'h0000_0010, IMM_J, 32'hFFFFFFFC);
        applyStimulus(32'h3400D073, 32'h0000_0014, IMM_C, 32'h00000001);
        applyStimulus(32'hFFFFFFFF, 32'h0000_0018, IMM_NONE, 32'h00000000);
        applyStimulus(32'hFFFFFFFF, 32'h0000_001C, 3'd7, 32'h00000000);
        for (int i = 0; i < 8; i++) begin
            rInstr = $urandom;
            rType  = 3'($urandom_range(0, 7));
            applyStimulus(rInstr, 32'h200 + 32'(i * 4), rType, refImm(rInstr, rType));
        end
        drainQueue();
        checkLatency = 1'b0;

        // Backpressure: A, B fill both slots, C is held at the input
        $display("[TB] backpressure");
        syncInputs();
        out_ready = 1'b0;
        applyStimulus(32'h00100093, 32'h100, IMM_I, 32'h00000001);
        applyStimulus(32'h00200093, 32'h104, IMM_I, 32'h00000002);
        @(negedge clk);
        checkOutput("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        driveInput(32'h00300093, 32'h108, IMM_I, 32'h00000003);
        repeat (2) begin
            @(negedge clk);
            checkOutput("bp_hold_pc", out_pc, 32'h100);
            checkOutput("bp_hold_imm", out_imm, 32'h00000001);
            checkOutput("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        syncInputs();
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_first_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_first_pc", out_pc, 32'h100);
        @(negedge clk);
        checkOutput("bp_second_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_second_pc", out_pc, 32'h104);
        checkOutput("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        syncInputs();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_third_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_third_pc", out_pc, 32'h108);
        drainQueue();

        // Flush with both slots full and a new input in the same cycle
        $display("[TB] flush");
        syncInputs();
        out_ready = 1'b0;
        applyStimulus(32'h00400093, 32'h300, IMM_I, 32'h00000004);
        applyStimulus(32'h00500093, 32'h304, IMM_I, 32'h00000005);
        driveInput(32'h00600093, 32'h308, IMM_I, 32'h00000006);
        flush = 1'b1;
        syncInputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
        syncInputs();
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("flush_no_output", {31'b0, out_valid}, 32'd0);
        end

        // Reset mid-stream with both slots full
        $display("[TB] reset mid-stream");
        syncInputs();
        out_ready = 1'b0;
        applyStimulus(32'h00700093, 32'h400, IMM_I, 32'h00000007);
        applyStimulus(32'h00800093, 32'h404, IMM_I, 32'h00000008);
        rst = 1'b1;
        syncInputs();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mrst_out_imm", out_imm, 32'h0);
        checkOutput("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        syncInputs();
        out_ready    = 1'b1;
        checkLatency = 1'b1;
        applyStimulus(32'h12345037, 32'h500, IMM_U, 32'h12345000);
        drainQueue();
        checkLatency = 1'b0;
        @(negedge clk);
        checkOutput("mrst_alone", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
